if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RISC-V core.
- Owns the program counter and drives the fetch address to the combinational instruction memory. The memory returns the instruction in the same cycle.
- Captures the fetched word into the IF/ID pipeline register.
- Handles stall (hazard unit) and redirect/flush (taken branch, JAL, JALR resolved downstream).
- Keeps saturating fetch and flush counters for bring-up.

---
 rtl/if_stage.sv | 78 +++++++
 tb/tb_if_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch stage with PC, IF/ID register and bring-up counters
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      pc_out,
  input  logic [31:0]      instruction,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] flush_count
);
  logic [31:0]      r_pc;
  logic [31:0]      r_id_pc;
  logic [31:0]      r_id_pc4;
  logic [31:0]      r_id_instr;
  logic             r_id_valid;
  logic             r_mis;
  logic [CNT_W-1:0] r_fcnt;
  logic [CNT_W-1:0] r_xcnt;
  logic [31:0]      w_pc4;
  logic             w_fetch;

  assign w_pc4   = r_pc + 32'd4;
  assign w_fetch = !redirect && !stall;

  // PC and IF/ID register: redirect flushes, stall holds, otherwise advance
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pc       <= {RESET_PC[31:2], 2'b00};
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (redirect) begin
      r_pc       <= {redirect_target[31:2], 2'b00};
      r_id_pc    <= '0;
      r_id_pc4   <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_pc4;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc4;
      r_id_instr <= instruction;
      r_id_valid <= 1'b1;
    end

  // Saturating counters and sticky misaligned-target flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_mis  <= 1'b0;
      r_fcnt <= '0;
      r_xcnt <= '0;
    end else begin
      if (redirect && redirect_target[1:0] != 2'b00) r_mis <= 1'b1;
      if (redirect) r_xcnt <= r_xcnt + CNT_W'(!(&r_xcnt));
      if (w_fetch) r_fcnt <= r_fcnt + CNT_W'(!(&r_fcnt));
    end

  assign pc_out         = r_pc;
  assign if_id_pc       = r_id_pc;
  assign if_id_pc_plus4 = r_id_pc4;
  assign if_id_instr    = r_id_instr;
  assign if_id_valid    = r_id_valid;
  assign misalign_err   = r_mis;
  assign fetch_count    = r_fcnt;
  assign flush_count    = r_xcnt;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed check of if_stage against a behavioural fetch model
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] tgt, instruction;
  logic [31:0] pc_out, if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid, misalign_err;
  logic [15:0] fetch_count, flush_count;
  logic [31:0] pc_b, ipc_b, ip4_b, ins_b;
  logic        v_b, mis_b;
  logic [3:0]  fc4, xc4;
  int n = 0, bad = 0;
  logic        en = 1'b0;
  logic [31:0] m_pc, m_ipc, m_ip4, m_ins;
  logic        m_v, m_mis;
  int          m_f, m_x;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h100 + a;
  endfunction

  assign instruction = mem(pc_out);

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_target(tgt),
    .pc_out(pc_out), .instruction(instruction), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count), .flush_count(flush_count)
  );

  if_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_target(tgt),
    .pc_out(pc_b), .instruction(instruction), .if_id_pc(ipc_b),
    .if_id_pc_plus4(ip4_b), .if_id_instr(ins_b), .if_id_valid(v_b),
    .misalign_err(mis_b), .fetch_count(fc4), .flush_count(xc4)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic mreset();
    m_pc = 0; m_ipc = 0; m_ip4 = 0; m_ins = NOP; m_v = 0; m_mis = 0; m_f = 0; m_x = 0;
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect = r; tgt = t;
    @(posedge clk);
    if (r) begin
      m_pc = t & 32'hFFFF_FFFC; m_ipc = 0; m_ip4 = 0; m_ins = NOP; m_v = 0; m_x++;
      if (t[1:0] != 0) m_mis = 1;
    end else if (!s) begin
      m_ipc = m_pc; m_ip4 = m_pc + 4; m_ins = mem(m_pc); m_v = 1; m_pc = m_pc + 4; m_f++;
    end
    #2;
  endtask

  always @(negedge clk) if (en) begin
    chk("pc_out", pc_out, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_ip4);
    chk("if_id_instr", if_id_instr, m_ins);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("fetch_count", {16'b0, fetch_count}, sat(m_f, 16'hFFFF));
    chk("flush_count", {16'b0, flush_count}, sat(m_x, 16'hFFFF));
    chk("fetch_count4", {28'b0, fc4}, sat(m_f, 15));
    chk("flush_count4", {28'b0, xc4}, sat(m_x, 15));
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; tgt = 0;
    mreset();
    en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    chk("lit_stall_pc", pc_out, 32'h8);
    chk("lit_stall_idpc", if_id_pc, 32'h4);
    chk("lit_stall_fc", {16'b0, fetch_count}, 32'd2);
    step(0, 0, 0); step(0, 0, 0);
    chk("lit_run_idpc", if_id_pc, 32'hC);
    chk("lit_run_instr", if_id_instr, 32'h10C);
    chk("lit_run_p4", if_id_pc_plus4, 32'h10);
    chk("lit_run_fc", {16'b0, fetch_count}, 32'd4);
    step(1, 1, 32'h40);
    chk("lit_redir_pc", pc_out, 32'h40);
    chk("lit_redir_instr", if_id_instr, 32'h13);
    chk("lit_redir_v", {31'b0, if_id_valid}, 32'd0);
    chk("lit_redir_xc", {16'b0, flush_count}, 32'd1);
    step(0, 0, 0);
    chk("lit_after_redir", if_id_pc, 32'h40);
    step(0, 1, 32'h22);
    chk("lit_mis_pc", pc_out, 32'h20);
    chk("lit_mis", {31'b0, misalign_err}, 32'd1);
    repeat (3) step(0, 0, 0);
    chk("lit_mis_sticky", {31'b0, misalign_err}, 32'd1);
    step(0, 1, 32'hFFFF_FFFC); step(0, 0, 0);
    chk("lit_wrap_idpc", if_id_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_pc", pc_out, 32'h0);
    chk("lit_wrap_p4", if_id_pc_plus4, 32'h0);
    step(0, 1, 32'h100); step(0, 1, 32'h200);
    chk("lit_b2b_pc", pc_out, 32'h200);
    chk("lit_b2b_xc", {16'b0, flush_count}, 32'd5);
    step(0, 0, 0);
    #1 reset = 1'b0;
    mreset();
    #1;
    chk("lit_arst_pc", pc_out, 32'h0);
    chk("lit_arst_instr", if_id_instr, NOP);
    chk("lit_arst_v", {31'b0, if_id_valid}, 32'd0);
    chk("lit_arst_mis", {31'b0, misalign_err}, 32'd0);
    chk("lit_arst_fc", {16'b0, fetch_count}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 6) == 0);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(s, r, t);
    end
    chk("lit_sat_fc4", {28'b0, fc4}, 32'hF);
    @(negedge clk);
    #1 en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
